// File: rtl/pipe_pkg.sv
// Shared types and per-boundary bundle widths for the core's pipeline-stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int unsigned IF_ID_WIDTH  = 32'd64;
  localparam int unsigned ID_EX_WIDTH  = 32'd150;
  localparam int unsigned EX_MEM_WIDTH = 32'd101;
  localparam int unsigned MEM_WB_WIDTH = 32'd71;

  // Number of held entries encoded by a state; unknown encodings report empty.
  function automatic logic [1:0] state_occupancy(input pipe_state_t s);
    logic [1:0] occ;
    case (s)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline-stage register with flush and optional skid entry.
// A bubble always presents an all-zero payload so it decodes as a NOP bundle.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32'd32,
  parameter bit          SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  localparam logic [WIDTH-1:0] ZERO_D = {WIDTH{1'b0}};

  pipe_state_t      state_r;
  pipe_state_t      state_s;
  logic [WIDTH-1:0] main_d_r;
  logic [WIDTH-1:0] main_d_s;
  logic [WIDTH-1:0] skid_d_r;
  logic [WIDTH-1:0] skid_d_s;
  logic             main_v_r;
  logic             skid_v_r;
  logic [1:0]       occ_r;
  logic             in_ready_s;
  logic             in_fire_s;
  logic             out_fire_s;

  // With a skid entry in_ready is a flop output; without it, a full stage
  // can only accept when the downstream is draining in the same cycle.
  generate
    if (SKID) begin : g_skid
      assign in_ready_s = ~skid_v_r;
    end else begin : g_noskid
      assign in_ready_s = ~main_v_r | out_ready;
    end
  endgenerate

  assign in_fire_s  = in_valid & in_ready_s;
  assign out_fire_s = main_v_r & out_ready;

  assign in_ready  = in_ready_s;
  assign out_valid = main_v_r;
  assign out_data  = main_d_r;
  assign occupancy = occ_r;

  // Next-state and next-payload selection; flush overrides every transfer.
  always_comb begin
    state_s  = state_r;
    main_d_s = main_d_r;
    skid_d_s = skid_d_r;
    if (flush) begin
      state_s  = EMPTY;
      main_d_s = ZERO_D;
      skid_d_s = ZERO_D;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            state_s  = ONE;
            main_d_s = in_data;
          end else begin
            state_s  = EMPTY;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_s  = ONE;
            main_d_s = in_data;
          end else if (in_fire_s) begin
            if (SKID) begin
              state_s  = FULL;
              skid_d_s = in_data;
            end else begin
              // Not reachable without a skid entry; replacing main keeps it safe.
              state_s  = ONE;
              main_d_s = in_data;
            end
          end else if (out_fire_s) begin
            state_s  = EMPTY;
            main_d_s = ZERO_D;
          end else begin
            state_s  = ONE;
          end
        end
        FULL: begin
          if (out_fire_s) begin
            state_s  = ONE;
            main_d_s = skid_d_r;
          end else begin
            state_s  = FULL;
          end
        end
        default: begin
          state_s  = EMPTY;
          main_d_s = ZERO_D;
          skid_d_s = ZERO_D;
        end
      endcase
    end
  end

  // State, payload and registered status flags; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= EMPTY;
      main_d_r <= ZERO_D;
      skid_d_r <= ZERO_D;
      main_v_r <= 1'b0;
      skid_v_r <= 1'b0;
      occ_r    <= 2'd0;
    end else begin
      state_r  <= state_s;
      main_d_r <= main_d_s;
      skid_d_r <= skid_d_s;
      main_v_r <= (state_s != EMPTY);
      skid_v_r <= (state_s == FULL);
      occ_r    <= state_occupancy(state_s);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: a skid and a non-skid stage driven in parallel, checked
// every cycle against queue models, plus directed literal checks.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        r1_in_ready, r1_out_valid;
  logic [31:0] r1_out_data;
  logic [1:0]  r1_occ;
  logic        r0_in_ready, r0_out_valid;
  logic [31:0] r0_out_data;
  logic [1:0]  r0_occ;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] q1[$];
  logic [31:0] q0[$];

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b1)) dut_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(r1_in_ready), .in_data(in_data),
    .out_valid(r1_out_valid), .out_ready(out_ready), .out_data(r1_out_data),
    .occupancy(r1_occ)
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b0)) dut_noskid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(r0_in_ready), .in_data(in_data),
    .out_valid(r0_out_valid), .out_ready(out_ready), .out_data(r0_out_data),
    .occupancy(r0_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model outputs derived from queue contents and capacity rules.
  task automatic check_model();
    logic [31:0] e1, e0;
    e1 = (q1.size() > 0) ? q1[0] : 32'd0;
    e0 = (q0.size() > 0) ? q0[0] : 32'd0;
    chk("skid.out_valid", {31'd0, r1_out_valid}, {31'd0, q1.size() > 0});
    chk("skid.out_data",  r1_out_data, e1);
    chk("skid.occupancy", {30'd0, r1_occ}, q1.size());
    chk("skid.in_ready",  {31'd0, r1_in_ready}, {31'd0, q1.size() < 2});
    chk("noskid.out_valid", {31'd0, r0_out_valid}, {31'd0, q0.size() > 0});
    chk("noskid.out_data",  r0_out_data, e0);
    chk("noskid.occupancy", {30'd0, r0_occ}, q0.size());
    chk("noskid.in_ready",  {31'd0, r0_in_ready}, {31'd0, (q0.size() == 0) || out_ready});
  endtask

  // One clock: compare mid-cycle, then advance the model across the edge.
  task automatic tick();
    bit f1_in, f1_out, f0_in, f0_out;
    @(negedge clk);
    check_model();
    f1_in  = in_valid && (q1.size() < 2);
    f1_out = (q1.size() > 0) && out_ready;
    f0_in  = in_valid && ((q0.size() == 0) || out_ready);
    f0_out = (q0.size() > 0) && out_ready;
    @(posedge clk);
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (f1_out) void'(q1.pop_front());
      if (f1_in)  q1.push_back(in_data);
      if (f0_out) void'(q0.pop_front());
      if (f0_in)  q0.push_back(in_data);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", {31'd0, r1_out_valid}, 32'd0);
    chk("reset.out_data",  r1_out_data, 32'd0);
    chk("reset.occupancy", {30'd0, r1_occ}, 32'd0);
    chk("reset.in_ready",  {31'd0, r1_in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Streaming with no backpressure: each value appears right after its edge.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, k, 1'b1, 1'b0);
      tick();
      chk("stream.out_valid", {31'd0, r1_out_valid}, 32'd1);
      chk("stream.out_data",  r1_out_data, k);
      chk("stream.noskid_data", r0_out_data, k);
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    tick();

    // Backpressure: A, B fill the skid stage, C waits until space frees.
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    tick();
    chk("bp.occ_after_A", {30'd0, r1_occ}, 32'd1);
    chk("bp.ready_after_A", {31'd0, r1_in_ready}, 32'd1);
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    tick();
    chk("bp.occ_after_B", {30'd0, r1_occ}, 32'd2);
    chk("bp.ready_after_B", {31'd0, r1_in_ready}, 32'd0);
    chk("bp.data_A_held", r1_out_data, 32'hA);
    drive(1'b1, 32'hC, 1'b0, 1'b0);
    tick();
    chk("bp.still_full", {30'd0, r1_occ}, 32'd2);
    chk("bp.data_A_stall", r1_out_data, 32'hA);
    drive(1'b1, 32'hC, 1'b1, 1'b0);
    tick();
    chk("bp.data_B", r1_out_data, 32'hB);
    chk("bp.ready_back", {31'd0, r1_in_ready}, 32'd1);
    tick();
    chk("bp.data_C", r1_out_data, 32'hC);
    chk("bp.occ_C", {30'd0, r1_occ}, 32'd1);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    chk("bp.drained_valid", {31'd0, r1_out_valid}, 32'd0);
    chk("bp.drained_data",  r1_out_data, 32'd0);

    // Flush in FULL with a simultaneous input that must be discarded.
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hD, 1'b0, 1'b1);
    tick();
    chk("flush.out_valid", {31'd0, r1_out_valid}, 32'd0);
    chk("flush.out_data",  r1_out_data, 32'd0);
    chk("flush.occupancy", {30'd0, r1_occ}, 32'd0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush.no_D", {31'd0, r1_out_valid}, 32'd0);
    end

    // Asynchronous reset while FULL, checked without any clock edge.
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h44, 1'b0, 1'b0);
    tick();
    chk("areset.pre_full", {30'd0, r1_occ}, 32'd2);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("areset.out_valid", {31'd0, r1_out_valid}, 32'd0);
    chk("areset.out_data",  r1_out_data, 32'd0);
    chk("areset.occupancy", {30'd0, r1_occ}, 32'd0);
    chk("areset.in_ready",  {31'd0, r1_in_ready}, 32'd1);
    chk("areset.noskid_valid", {31'd0, r0_out_valid}, 32'd0);
    q1.delete();
    q0.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Non-skid stage: in_ready follows out_ready combinationally while full.
    drive(1'b1, 32'h100, 1'b1, 1'b0);
    tick();
    chk("noskid.full", {30'd0, r0_occ}, 32'd1);
    out_ready = 1'b0;
    #1;
    chk("noskid.ready_low", {31'd0, r0_in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("noskid.ready_high", {31'd0, r0_in_ready}, 32'd1);
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 32'h100 + i, (i % 2) == 0, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    repeat (3) tick();

    // Randomized traffic against the queue models.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
